ex_104_structure_demux_seq: RTL



---
 rtl/ex_104_pkg.sv | 21 ++
 rtl/ex_104_structure_demux_seq_dest_decode.sv | 28 ++
 rtl/ex_104_structure_demux_seq.sv | 113 +++++++++++
 3 files changed

// File: rtl/ex_104_pkg.sv
// ex_104_pkg: shared constants and types for the six-way registered distributor.
//   DST_A..DST_F : destination indices (bit position in out_vld / out_ack)
//   state_e      : distributor FSM state encoding
package ex_104_pkg;

   localparam int unsigned N_DST = 6;

   localparam logic [2:0] DST_A = 3'd0;
   localparam logic [2:0] DST_B = 3'd1;
   localparam logic [2:0] DST_C = 3'd2;
   localparam logic [2:0] DST_D = 3'd3;
   localparam logic [2:0] DST_E = 3'd4;
   localparam logic [2:0] DST_F = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_STALL = 2'd2
   } state_e;

endpackage

// File: rtl/ex_104_structure_demux_seq_dest_decode.sv
// ex_104_dest_decode: combinational fixed-priority destination decoder.
//   sel1_i..sel5_i : destination select bits
//   dest_o         : destination index (DST_A..DST_F)
//   onehot_o       : one-hot form of dest_o, bit 0 = a .. bit 5 = f
module ex_104_dest_decode
   import ex_104_pkg::*;
(
   input  logic       sel1_i,
   input  logic       sel2_i,
   input  logic       sel3_i,
   input  logic       sel4_i,
   input  logic       sel5_i,
   output logic [2:0] dest_o,
   output logic [5:0] onehot_o
);

   always_comb begin
      dest_o = DST_F;
      if (sel1_i)              dest_o = DST_A;
      else if (sel2_i && sel3_i) dest_o = DST_B;
      else if (sel2_i)         dest_o = DST_C;
      else if (sel4_i)         dest_o = DST_D;
      else if (sel5_i)         dest_o = DST_E;
   end

   assign onehot_o = 6'b000001 << dest_o;

endmodule

// File: rtl/ex_104_structure_demux_seq.sv
// ex_104_structure_demux_seq: registered six-way distributor for W-bit words.
//   clk, rst_n          : clock, synchronous active-low reset
//   g, in_valid         : input word and its valid
//   in_ready            : input accepted this cycle when in_valid is high
//   sel1..sel5          : destination select, sampled with g
//   a..f                : output holding registers
//   out_vld, out_ack    : per-destination valid / consume strobe (bit 0 = a)
//   word_cnt            : accepted-word count (wraps)
//   stall_cnt           : stalled-cycle count (saturates)
//   state               : FSM state (debug)
module ex_104_structure_demux_seq
   import ex_104_pkg::*;
#(
   parameter int unsigned W     = 5,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     g,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sel1,
   input  logic             sel2,
   input  logic             sel3,
   input  logic             sel4,
   input  logic             sel5,
   output logic [W-1:0]     a,
   output logic [W-1:0]     b,
   output logic [W-1:0]     c,
   output logic [W-1:0]     d,
   output logic [W-1:0]     e,
   output logic [W-1:0]     f,
   output logic [5:0]       out_vld,
   input  logic [5:0]       out_ack,
   output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [1:0]       state
);

   logic [2:0]       dest;
   logic [5:0]       dest_oh;
   logic             accept;
   logic             stall;

   logic [W-1:0]     data_q [N_DST];
   logic [W-1:0]     data_d [N_DST];
   logic [5:0]       vld_q, vld_d;
   logic [CNT_W-1:0] word_q, word_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   state_e           state_q, state_d;

   ex_104_dest_decode u_dec (
      .sel1_i   (sel1),
      .sel2_i   (sel2),
      .sel3_i   (sel3),
      .sel4_i   (sel4),
      .sel5_i   (sel5),
      .dest_o   (dest),
      .onehot_o (dest_oh)
   );

   // Ready is held low while reset is asserted so nothing looks accepted.
   assign in_ready = rst_n & (~vld_q[dest] | out_ack[dest]);
   assign accept   = in_valid & in_ready;
   assign stall    = in_valid & ~in_ready;

   always_comb begin
      for (int unsigned i = 0; i < N_DST; i++) begin
         data_d[i] = data_q[i];
         if (accept && dest_oh[i]) data_d[i] = g;
      end
      // Ack clears valid; a same-cycle accept into that slot re-sets it.
      vld_d   = (vld_q & ~out_ack) | (accept ? dest_oh : 6'b0);
      word_d  = accept ? word_q + CNT_W'(1) : word_q;
      stall_d = (stall && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
   end

   // Next state depends only on this cycle's inputs, so any stray encoding
   // (including 2'd3) is left after one clock.
   always_comb begin
      state_d = ST_IDLE;
      if (accept)     state_d = ST_XFER;
      else if (stall) state_d = ST_STALL;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_DST; i++) data_q[i] <= '0;
         vld_q   <= '0;
         word_q  <= '0;
         stall_q <= '0;
         state_q <= ST_IDLE;
      end else begin
         for (int unsigned i = 0; i < N_DST; i++) data_q[i] <= data_d[i];
         vld_q   <= vld_d;
         word_q  <= word_d;
         stall_q <= stall_d;
         state_q <= state_d;
      end
   end

   assign a         = data_q[DST_A];
   assign b         = data_q[DST_B];
   assign c         = data_q[DST_C];
   assign d         = data_q[DST_D];
   assign e         = data_q[DST_E];
   assign f         = data_q[DST_F];
   assign out_vld   = vld_q;
   assign word_cnt  = word_q;
   assign stall_cnt = stall_q;
   assign state     = state_q;

endmodule
